// File: rtl/alu_exec_pkg.sv
// rtl/alu_exec_pkg.sv - op codes, op classes and divider states for the integer execution unit
package alu_exec_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000100;
  localparam logic [5:0] OP_OR    = 6'b000101;
  localparam logic [5:0] OP_XOR   = 6'b000110;
  localparam logic [5:0] OP_MUL   = 6'b001000;
  localparam logic [5:0] OP_MULH  = 6'b001001;
  localparam logic [5:0] OP_MULHU = 6'b001010;
  localparam logic [5:0] OP_DIV   = 6'b001100;
  localparam logic [5:0] OP_DIVU  = 6'b001101;
  localparam logic [5:0] OP_REM   = 6'b001110;
  localparam logic [5:0] OP_REMU  = 6'b001111;
  localparam logic [5:0] OP_ADDI  = 6'b100000;
  localparam logic [5:0] OP_SLL   = 6'b100001;
  localparam logic [5:0] OP_SRA   = 6'b100010;
  localparam logic [5:0] OP_SRL   = 6'b100011;
  localparam logic [5:0] OP_SLT   = 6'b100100;
  localparam logic [5:0] OP_SLTU  = 6'b100101;
  localparam logic [5:0] OP_LUI   = 6'b101010;

  typedef enum logic [1:0] {CLS_SHORT, CLS_MUL, CLS_DIV} op_class_t;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;

  // Unknown codes fall into the short class and produce zero.
  function automatic op_class_t decode_class(input logic [5:0] ctl);
    case (ctl)
      OP_MUL, OP_MULH, OP_MULHU:          return CLS_MUL;
      OP_DIV, OP_DIVU, OP_REM, OP_REMU:   return CLS_DIV;
      default:                            return CLS_SHORT;
    endcase
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - issue and writeback handshake bundle of the execution unit
interface alu_exec_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       in_ctl;
  logic [XLEN-1:0]  in_op1;
  logic [XLEN-1:0]  in_op2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_res;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_ctl, in_op1, in_op2, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_tag
  );

  modport slave (
    input  in_valid, in_ctl, in_op1, in_op2, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_tag
  );
endinterface

// File: rtl/alu_divider.sv
// rtl/alu_divider.sv - iterative radix-2 restoring divider on magnitudes with sign fix-up
module alu_divider
  import alu_exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic            is_signed,
  input  logic            is_rem,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            ack,
  output logic            idle,
  output logic            done,
  output logic [XLEN-1:0] res
);
  localparam int CW = $clog2(XLEN);

  div_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] quo_q, rem_q, dvs_q, op1_q, res_q;
  logic            neg_a_q, neg_b_q, bz_q, rem_sel_q;
  logic [XLEN:0]   shifted, diff;
  logic [XLEN-1:0] q_fix, r_fix, fix_res;
  logic            neg_a, neg_b;

  assign neg_a = is_signed & op1[XLEN-1];
  assign neg_b = is_signed & op2[XLEN-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == CW'(XLEN-1)) state_d = FIX;
      FIX:     state_d = ack ? IDLE : DONE;
      DONE:    if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0; quo_q <= '0; rem_q <= '0; dvs_q <= '0; op1_q <= '0; res_q <= '0;
      neg_a_q <= 1'b0; neg_b_q <= 1'b0; bz_q <= 1'b0; rem_sel_q <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        quo_q     <= neg_a ? -op1 : op1;
        dvs_q     <= neg_b ? -op2 : op2;
        rem_q     <= '0;
        cnt_q     <= '0;
        op1_q     <= op1;
        neg_a_q   <= neg_a;
        neg_b_q   <= neg_b;
        bz_q      <= (op2 == '0);
        rem_sel_q <= is_rem;
      end else if (state_q == CALC) begin
        cnt_q <= cnt_q + 1'b1;
        if (!diff[XLEN]) begin
          rem_q <= diff[XLEN-1:0];
          quo_q <= {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_q <= shifted[XLEN-1:0];
          quo_q <= {quo_q[XLEN-2:0], 1'b0};
        end
      end else if (state_q == FIX) begin
        res_q <= fix_res;
      end
    end
  end

  // MIN / -1 falls out of the magnitude path naturally; only divide-by-zero needs overriding.
  always_comb begin
    q_fix = (neg_a_q ^ neg_b_q) ? -quo_q : quo_q;
    r_fix = neg_a_q ? -rem_q : rem_q;
    if (bz_q) begin
      q_fix = '1;
      r_fix = op1_q;
    end
    fix_res = rem_sel_q ? r_fix : q_fix;
  end

  assign idle = (state_q == IDLE);
  assign done = (state_q == FIX) || (state_q == DONE);
  assign res  = (state_q == DONE) ? res_q : fix_res;
endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - in-order integer execution unit: short ops, pipelined multiply, iterative divide
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 5,
  parameter int MUL_LAT = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  alu_exec_unit_if.slave io,
  output logic         busy
);
  localparam int NS = MUL_LAT - 1;
  localparam int SW = $clog2(XLEN);

  op_class_t         cls;
  logic              advance, mul_any, fire, mul_signed;
  logic              div_start, div_idle, div_done, div_signed, div_rem;
  logic [SW-1:0]     shamt;
  logic [XLEN-1:0]   short_res, mul_sel, div_res;
  logic [2*XLEN-1:0] mul_a, mul_b, mul_prod;
  logic [NS-1:0]     mul_v;
  logic [XLEN-1:0]   mul_res [NS];
  logic [TAG_W-1:0]  mul_tag [NS];
  logic [TAG_W-1:0]  div_tag;

  assign cls     = decode_class(io.in_ctl);
  assign advance = ~io.out_valid | io.out_ready;
  assign mul_any = |mul_v;
  // Short and divide ops must wait for the mul pipe to drain so results stay in order.
  assign io.in_ready = rst_n & ~flush & advance & div_idle & ((cls == CLS_MUL) | ~mul_any);
  assign fire      = io.in_valid & io.in_ready;
  assign div_start = fire & (cls == CLS_DIV);
  assign busy      = io.out_valid | mul_any | ~div_idle;
  assign shamt     = io.in_op2[SW-1:0];

  always_comb begin
    short_res = '0;
    case (io.in_ctl)
      OP_ADD, OP_ADDI: short_res = io.in_op1 + io.in_op2;
      OP_SUB:          short_res = io.in_op1 - io.in_op2;
      OP_AND:          short_res = io.in_op1 & io.in_op2;
      OP_OR:           short_res = io.in_op1 | io.in_op2;
      OP_XOR:          short_res = io.in_op1 ^ io.in_op2;
      OP_SLL:          short_res = io.in_op1 << shamt;
      OP_SRL:          short_res = io.in_op1 >> shamt;
      OP_SRA:          short_res = $unsigned($signed(io.in_op1) >>> shamt);
      OP_SLT:          short_res = {{(XLEN-1){1'b0}}, $signed(io.in_op1) < $signed(io.in_op2)};
      OP_SLTU:         short_res = {{(XLEN-1){1'b0}}, io.in_op1 < io.in_op2};
      OP_LUI:          short_res = io.in_op2;
      default:         short_res = '0;
    endcase
  end

  assign mul_signed = (io.in_ctl == OP_MULH);
  assign mul_a      = {{XLEN{mul_signed & io.in_op1[XLEN-1]}}, io.in_op1};
  assign mul_b      = {{XLEN{mul_signed & io.in_op2[XLEN-1]}}, io.in_op2};
  assign mul_prod   = mul_a * mul_b;
  assign mul_sel    = (io.in_ctl == OP_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_v <= '0;
      for (int k = 0; k < NS; k++) begin
        mul_res[k] <= '0;
        mul_tag[k] <= '0;
      end
    end else if (flush) begin
      mul_v <= '0;
    end else if (advance) begin
      mul_v[0]   <= fire & (cls == CLS_MUL);
      mul_res[0] <= mul_sel;
      mul_tag[0] <= io.in_tag;
      for (int k = 1; k < NS; k++) begin
        mul_v[k]   <= mul_v[k-1];
        mul_res[k] <= mul_res[k-1];
        mul_tag[k] <= mul_tag[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         div_tag <= '0;
    else if (div_start) div_tag <= io.in_tag;
  end

  assign div_signed = (io.in_ctl == OP_DIV) || (io.in_ctl == OP_REM);
  assign div_rem    = (io.in_ctl == OP_REM) || (io.in_ctl == OP_REMU);

  alu_divider #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .start     (div_start),
    .is_signed (div_signed),
    .is_rem    (div_rem),
    .op1       (io.in_op1),
    .op2       (io.in_op2),
    .ack       (advance),
    .idle      (div_idle),
    .done      (div_done),
    .res       (div_res)
  );

  // Issue rules make the three sources mutually exclusive in any one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.out_valid <= 1'b0;
      io.out_res   <= '0;
      io.out_tag   <= '0;
    end else if (flush) begin
      io.out_valid <= 1'b0;
    end else if (advance) begin
      if (mul_v[NS-1]) begin
        io.out_valid <= 1'b1;
        io.out_res   <= mul_res[NS-1];
        io.out_tag   <= mul_tag[NS-1];
      end else if (fire && cls == CLS_SHORT) begin
        io.out_valid <= 1'b1;
        io.out_res   <= short_res;
        io.out_tag   <= io.in_tag;
      end else if (div_done) begin
        io.out_valid <= 1'b1;
        io.out_res   <= div_res;
        io.out_tag   <= div_tag;
      end else begin
        io.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard bench for alu_exec_unit with directed vectors
module tb_alu_exec_unit;
  import alu_exec_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          cyc;
  } exp_t;

  logic clk, rst_n, flush, busy;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t mon_e;

  alu_exec_unit_if #(.XLEN(32), .TAG_W(5)) io ();

  alu_exec_unit #(.XLEN(32), .TAG_W(5), .MUL_LAT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .io    (io.slave),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && io.out_valid && io.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual res=%h tag=%0d required=none (cycle %0d)",
                 io.out_res, io.out_tag, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_res", 64'(io.out_res), 64'(mon_e.res));
        chk("sb_tag", 64'(io.out_tag), 64'(mon_e.tag));
        if (mon_e.cyc >= 0) chk("sb_latency", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic issue(input logic [5:0] ctl, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input bit push, input logic [31:0] res,
                       input int lat, output int acc);
    exp_t e;
    io.in_ctl = ctl; io.in_op1 = a; io.in_op2 = b; io.in_tag = tag; io.in_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (io.in_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) chk("issue_timeout", 64'd0, 64'd1);
    else if (push) begin
      e.res = res; e.tag = tag; e.cyc = (lat < 0) ? -1 : acc + lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 io.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  logic [5:0]  s_ctl [13] = '{OP_ADD, OP_SRA, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL,
                               OP_SRL, OP_SLT, OP_SLTU, OP_LUI, OP_ADDI, 6'b000010};
  logic [31:0] s_a   [13] = '{32'd5, 32'h80000000, 32'd3, 32'hF0F0F0F0, 32'hF0F0F0F0,
                               32'hFFFF0000, 32'd1, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'hDEADBEEF, 32'd10, 32'h12345678};
  logic [31:0] s_b   [13] = '{32'd7, 32'd4, 32'd5, 32'hFF00FF00, 32'h0F0F0000, 32'hFF00FF00,
                               32'd33, 32'd31, 32'd1, 32'd1, 32'h12345000, 32'hFFFFFFFF,
                               32'h11111111};
  logic [31:0] s_exp [13] = '{32'd12, 32'hF8000000, 32'hFFFFFFFE, 32'hF000F000, 32'hFFFFF0F0,
                               32'h00FFFF00, 32'd2, 32'd1, 32'd1, 32'd0, 32'h12345000,
                               32'd9, 32'd0};
  logic [5:0]  d_ctl [7] = '{OP_DIV, OP_REM, OP_DIVU, OP_REM, OP_DIV, OP_DIVU, OP_REMU};
  logic [31:0] d_a   [7] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7, 32'h80000000,
                              32'd100, 32'd100};
  logic [31:0] d_b   [7] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd7, 32'd7};
  logic [31:0] d_exp [7] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'h80000000,
                              32'd14, 32'd2};

  initial begin
    int acc, m0, prev;
    bit have;
    rst_n = 1'b0; flush = 1'b0;
    io.in_valid = 1'b0; io.in_ctl = '0; io.in_op1 = '0; io.in_op2 = '0; io.in_tag = '0;
    io.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(io.out_valid), 64'd0);
    chk("rst_out_res", 64'(io.out_res), 64'd0);
    chk("rst_out_tag", 64'(io.out_tag), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(io.in_ready), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) issue(s_ctl[i], s_a[i], s_b[i], 5'(i), 1'b1, s_exp[i], 1, acc);
    drain();

    issue(OP_MUL, 32'd3, 32'd4, 5'd1, 1'b1, 32'd12, 3, m0);
    issue(OP_MULHU, 32'hFFFFFFFF, 32'd2, 5'd2, 1'b1, 32'd1, 3, acc);
    chk("mul_back_to_back", 64'(acc - m0), 64'd1);
    issue(OP_MULH, 32'hFFFFFFFE, 32'd3, 5'd3, 1'b1, 32'hFFFFFFFF, 3, acc);
    issue(OP_ADD, 32'd1, 32'd1, 5'd4, 1'b1, 32'd2, 1, acc);
    chk("short_behind_mul_accept", 64'(acc - m0), 64'd5);
    drain();

    prev = -1;
    for (int i = 0; i < 7; i++) begin
      issue(d_ctl[i], d_a[i], d_b[i], 5'(16 + i), 1'b1, d_exp[i], 34, acc);
      if (prev >= 0) chk("div_issue_gap", 64'(acc - prev), 64'd34);
      prev = acc;
    end
    drain();

    io.out_ready = 1'b0;
    issue(OP_MUL, 32'd6, 32'd7, 5'd1, 1'b1, 32'd42, -1, acc);
    issue(OP_MUL, 32'h10000, 32'h10001, 5'd2, 1'b1, 32'h00010000, -1, acc);
    have = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (io.out_valid) begin
        have = 1'b1;
        chk("bp_hold_res", 64'(io.out_res), 64'd42);
        chk("bp_hold_tag", 64'(io.out_tag), 64'd1);
      end
    end
    chk("bp_output_seen", 64'(have), 64'd1);
    chk("bp_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1 io.out_ready = 1'b1;
    drain();

    issue(OP_DIV, 32'd100, 32'd7, 5'd7, 1'b0, 32'd0, -1, acc);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    io.in_ctl = OP_ADD; io.in_op1 = 32'd1; io.in_op2 = 32'd1; io.in_tag = 5'd9;
    io.in_valid = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(io.in_ready), 64'd0);
    chk("flush_busy_before", 64'(busy), 64'd1);
    @(posedge clk);
    #1 flush = 1'b0;
    io.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("flush_busy_after", 64'(busy), 64'd0);
    chk("flush_out_valid", 64'(io.out_valid), 64'd0);
    repeat (40) @(negedge clk);
    @(posedge clk);
    #1;

    issue(OP_MUL, 32'd2, 32'd2, 5'd1, 1'b0, 32'd0, -1, acc);
    issue(OP_MUL, 32'd2, 32'd3, 5'd2, 1'b0, 32'd0, -1, acc);
    issue(OP_MUL, 32'd2, 32'd4, 5'd3, 1'b0, 32'd0, -1, acc);
    #1;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    chk("pre_rst_out_valid", 64'(io.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(io.out_valid), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_in_ready", 64'(io.in_ready), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", 64'(io.out_valid), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    issue(OP_ADD, 32'd5, 32'd7, 5'd3, 1'b1, 32'd12, 1, acc);
    issue(OP_MUL, 32'd3, 32'd4, 5'd4, 1'b1, 32'd12, 3, acc);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
